// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit constants, state encoding and fetch control payload.
package cpu_ctrl_pkg;

    localparam int unsigned T_W = 4;

    localparam logic [1:0] FUN_DEC  = 2'b00;
    localparam logic [1:0] FUN_INC  = 2'b01;
    localparam logic [1:0] FUN_LOAD = 2'b10;
    localparam logic [1:0] FUN_CLR  = 2'b11;

    localparam logic [3:0] ARF_SEL_PC   = 4'b0111;
    localparam logic [3:0] ARF_SEL_NONE = 4'b1111;

    localparam logic [1:0] OUTD_PC = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    typedef struct packed {
        logic       mem_cs;
        logic       mem_wr;
        logic [1:0] arf_outd_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_reg_sel;
        logic       ir_enable;
        logic       ir_lh;
        logic [1:0] ir_funsel;
    } fetch_ctrl_t;

    localparam fetch_ctrl_t CTRL_INACTIVE = '{
        mem_cs:       1'b1,
        mem_wr:       1'b0,
        arf_outd_sel: OUTD_PC,
        arf_fun_sel:  FUN_INC,
        arf_reg_sel:  ARF_SEL_NONE,
        ir_enable:    1'b0,
        ir_lh:        1'b0,
        ir_funsel:    FUN_LOAD
    };

    // Moore decode of the memory/ARF/IR control lines for a given state.
    function automatic fetch_ctrl_t decode_ctrl(input state_t s);
        fetch_ctrl_t c;
        c = CTRL_INACTIVE;
        if (s == ST_FETCH_L || s == ST_FETCH_H) begin
            c.mem_cs      = 1'b0;
            c.arf_reg_sel = ARF_SEL_PC;
            c.ir_enable   = 1'b1;
            c.ir_lh       = (s == ST_FETCH_H);
        end
        return c;
    endfunction

endpackage

// File: rtl/t_state_counter.sv
// T-state counter: synchronous clear, enable, saturates at MAX_T.
module t_state_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MAX_T = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           enable,
    output logic [T_W-1:0] count
);

    // Count register; clear wins over enable, holds once MAX_T is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != T_W'(MAX_T))) begin
            count <= count + T_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/timing sequencer: two-byte instruction fetch, handoff to execute, halt and timeout.
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MAX_T   = 15,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Exec_Done,
    input  logic               Halt_Req,
    output logic [T_W-1:0]     timing_signal,
    output logic               Mem_CS,
    output logic               Mem_WR,
    output logic [1:0]         ARF_OutDSel,
    output logic [1:0]         ARF_FunSel,
    output logic [3:0]         ARF_RegSel,
    output logic               IR_Enable,
    output logic               IR_LH,
    output logic [1:0]         IR_Funsel,
    output logic               Instr_Valid,
    output logic               Halted,
    output logic               Error,
    output logic [COUNT_W-1:0] Retired
);

    state_t      state;
    state_t      state_next;
    fetch_ctrl_t ctrl_q;
    fetch_ctrl_t ctrl_next;
    logic        retire;
    logic        timeout;
    logic        t_clear;
    logic        t_enable;

    // T-state counter runs through fetch and execute, cleared at every boundary.
    t_state_counter #(
        .MAX_T (MAX_T)
    ) u_t_state_counter (
        .clk    (Clock),
        .rst_n  (Reset),
        .clear  (t_clear),
        .enable (t_enable),
        .count  (timing_signal)
    );

    // Next-state, retire/timeout strobes and decoded controls for the next state.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            ST_IDLE, ST_HALT: begin
                if (Start) state_next = ST_FETCH_L;
            end
            ST_FETCH_L: state_next = ST_FETCH_H;
            ST_FETCH_H: state_next = ST_EXEC;
            ST_EXEC: begin
                if (Exec_Done) begin
                    retire     = 1'b1;
                    state_next = Halt_Req ? ST_HALT : ST_FETCH_L;
                end else if (timing_signal == T_W'(MAX_T)) begin
                    timeout    = 1'b1;
                    state_next = ST_HALT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        ctrl_next = decode_ctrl(state_next);
        t_enable  = (state_next == ST_FETCH_H) || (state_next == ST_EXEC);
        t_clear   = !t_enable;
    end

    // State and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            ctrl_q      <= CTRL_INACTIVE;
            Instr_Valid <= 1'b0;
            Halted      <= 1'b0;
            Error       <= 1'b0;
            Retired     <= '0;
        end else begin
            state       <= state_next;
            ctrl_q      <= ctrl_next;
            Instr_Valid <= (state == ST_FETCH_H) && (state_next == ST_EXEC);
            Halted      <= (state_next == ST_HALT);
            Error       <= Error | timeout;
            if (retire) Retired <= Retired + COUNT_W'(1);
        end
    end

    assign Mem_CS      = ctrl_q.mem_cs;
    assign Mem_WR      = ctrl_q.mem_wr;
    assign ARF_OutDSel = ctrl_q.arf_outd_sel;
    assign ARF_FunSel  = ctrl_q.arf_fun_sel;
    assign ARF_RegSel  = ctrl_q.arf_reg_sel;
    assign IR_Enable   = ctrl_q.ir_enable;
    assign IR_LH       = ctrl_q.ir_lh;
    assign IR_Funsel   = ctrl_q.ir_funsel;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Timing and fetch control stage directly upstream of ALU_System, inside the control unit.
- Generates the T-state counter (timing_signal) and drives the memory/ARF/IR control lines that fetch each 16-bit instruction as two bytes: low byte at PC, then high byte at PC+1, with PC incremented after each byte.
- Hands the instruction to the execute decoder via Instr_Valid. Waits for Exec_Done, then fetches the next instruction.

Parameters:
- MAX_T, 15, last legal T-state. Reaching it in EXEC without Exec_Done is a timeout.
- COUNT_W, 8, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low
- Start  in  1  level; leaves IDLE or HALT
- Exec_Done  in  1  execute decoder finished the current instruction
- Halt_Req  in  1  stop at the next instruction boundary
- timing_signal  out  4  current T-state
- Mem_CS  out  1  memory chip select, active-low
- Mem_WR  out  1  0 = read; always 0 from this block
- ARF_OutDSel  out  2  ARF address-output select
- ARF_FunSel  out  2  ARF function
- ARF_RegSel  out  4  ARF register enables, active-low, bit3 = PC
- IR_Enable  out  1  IR load enable
- IR_LH  out  1  0 = low byte, 1 = high byte
- IR_Funsel  out  2  IR function
- Instr_Valid  out  1  one-cycle pulse: IR holds a complete instruction
- Halted  out  1  high while in HALT
- Error  out  1  sticky timeout flag
- Retired  out  COUNT_W  number of instructions whose Exec_Done was accepted

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state IDLE, timing_signal 0
  - Mem_CS 1, Mem_WR 0, IR_Enable 0, IR_LH 0, IR_Funsel FUN_LOAD
  - ARF_RegSel 4'b1111, ARF_FunSel FUN_INC, ARF_OutDSel OUTD_PC
  - Instr_Valid 0, Halted 0, Error 0, Retired 0
- States: IDLE, FETCH_L, FETCH_H, EXEC, HALT. Control outputs are Moore-decoded from state. Counters are registered.
- IDLE: all enables inactive, timing_signal 0.
  - Start=1 -> FETCH_L on the next edge.
- FETCH_L, timing_signal 0:
  - Mem_CS 0, ARF_OutDSel OUTD_PC, IR_Enable 1, IR_LH 0, IR_Funsel FUN_LOAD
  - ARF_RegSel 4'b0111, ARF_FunSel FUN_INC
  - -> FETCH_H
- FETCH_H, timing_signal 1: same as FETCH_L except IR_LH 1. -> EXEC.
- EXEC:
  - timing_signal 2 on entry, +1 per cycle, saturating at MAX_T.
  - Fetch enables inactive, Mem_CS 1, ARF_RegSel 1111.
  - Instr_Valid=1 only in the first EXEC cycle (T2).
- Exec_Done in EXEC (sampled at the clock edge, any T >= 2, including T2):
  - Retired+1, wrapping 2^COUNT_W-1 -> 0.
  - Halt_Req=1 in the same cycle -> HALT; otherwise -> FETCH_L, T back to 0 with no bubble.
- Timeout: in EXEC with timing_signal=MAX_T and Exec_Done=0 -> Error<=1, -> HALT.
  - Exec_Done at MAX_T takes priority over the timeout.
- Exec_Done outside EXEC is ignored.
- Halt_Req outside EXEC is ignored. Halt takes effect only at an instruction boundary; a fetch is never aborted.
- HALT: Halted=1, outputs as IDLE, timing_signal 0.
  - Start=1 -> FETCH_L.
  - Error is cleared only by Reset.
- Start held high continuously has no effect outside IDLE and HALT.
- Reset mid-fetch: return to IDLE immediately. A partially loaded IR is left as is and no Instr_Valid is produced.

Decomposition:
- Package cpu_ctrl_pkg holds the shared constants:
  - FUN_DEC=2'b00, FUN_INC=2'b01, FUN_LOAD=2'b10, FUN_CLR=2'b11
  - ARF_SEL_PC=4'b0111, ARF_SEL_NONE=4'b1111
  - OUTD_PC=2'b11
  - state encoding localparams
- One sub-module: t_state_counter, a 4-bit counter with clear, enable and saturation at MAX_T, reused by the execute decoder.

Test Plan:
- Reset low for 2 cycles, then release -> all outputs at reset values; timing_signal 0; Mem_CS 1; ARF_RegSel 1111.
- Start=1 for 1 cycle, Exec_Done at T4:
  - FETCH_L: T=0, IR_LH=0, IR_Enable=1, ARF_RegSel=0111
  - FETCH_H: T=1, IR_LH=1
  - EXEC: T=2 with Instr_Valid=1, then T=3, T=4
  - next cycle FETCH_L (T=0); Retired=1
- Exec_Done=1 at T2 for 10 consecutive instructions -> period of 3 cycles each; Retired=10; no idle cycles between instructions.
- Halt_Req=1 asserted at T3, Exec_Done at T5 -> HALT, Halted=1, Retired incremented; then Start=1 -> FETCH_L, Halted=0.
- Exec_Done withheld -> T saturates at 15, Error=1, HALT. Start resumes fetching; Error stays 1 until Reset.
- Extra checks:
  - Reset pulsed during FETCH_H -> IDLE asynchronously, no Instr_Valid pulse.
  - COUNT_W=8 after 256 retired instructions -> Retired wraps to 0.
